// File: rtl/offchip_memory_pkg.sv
// Shared definitions for the off-chip memory model: word width, default
// geometry/latency and the controller state encoding.
package offchip_memory_pkg;

  localparam int WORD_W  = 16;
  localparam int DEF_AW  = 10;
  localparam int DEF_LAT = 2;
  localparam int LAT_W   = 4;

  typedef enum logic [3:0] {
    IDLE,
    R_ACK,
    R_LAT,
    R_DATA,
    R_GAP,
    W_AACK,
    W_DWAIT,
    W_DACK,
    W_DONE
  } state_t;

  // Word slot within a 4-word block; wraps inside the block.
  function automatic logic [1:0] next_word(input logic [1:0] w);
    return w + 2'd1;
  endfunction

endpackage

// File: rtl/offchip_ram.sv
// Word storage: one synchronous write port, one asynchronous read port.
module offchip_ram
  import offchip_memory_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**AW];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/offchip_memory.sv
// Off-chip memory model on a shared 16-bit address/data bus. Reads return
// an aligned 4-word burst with a fixed latency before every word; writes
// take an address phase and a data phase, optionally followed by a
// burst read of the written block (write-allocate).
module offchip_memory
  import offchip_memory_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int LAT = DEF_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rrqst,
  output logic              rrdy,
  output logic              rdrdy,
  input  logic              rdacpt,
  input  logic              wrqst,
  output logic              wacpt,
  inout  wire  [WORD_W-1:0] offdata
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT);

  state_t            state_q;
  logic              rrdy_q;
  logic              rdrdy_q;
  logic              wacpt_q;
  logic [WORD_W-1:0] rd_data_q;
  logic [AW-3:0]     base_q;
  logic [1:0]        wordcnt_q;
  logic [LAT_W-1:0]  lat_q;
  logic [AW-1:0]     addr_q;
  logic              rd_alloc_q;

  logic [AW-1:0]     bus_addr;
  logic [AW-1:0]     ram_raddr;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_we;

  // Only the low AW bus bits form an address; the rest are don't-care.
  assign bus_addr = offdata[AW-1:0];

  generate
    if (AW < WORD_W) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^offdata[WORD_W-1:AW];
    end
  endgenerate

  assign ram_raddr = {base_q, wordcnt_q};
  // The data-phase edge commits the write; a coincident reset cancels it.
  assign ram_we    = (state_q == W_DWAIT) && wrqst && !reset;

  offchip_ram #(
    .AW (AW)
  ) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (addr_q),
    .wdata_i (offdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Bus is driven only while a read word is being presented.
  assign offdata = rdrdy_q ? rd_data_q : {WORD_W{1'bz}};
  assign rrdy    = rrdy_q;
  assign rdrdy   = rdrdy_q;
  assign wacpt   = wacpt_q;

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rrdy_q     <= 1'b0;
      rdrdy_q    <= 1'b0;
      wacpt_q    <= 1'b0;
      rd_data_q  <= '0;
      base_q     <= '0;
      wordcnt_q  <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      rd_alloc_q <= 1'b0;
    end else begin
      rrdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wrqst) begin
            // A simultaneous read request turns into write-allocate.
            addr_q     <= bus_addr;
            rd_alloc_q <= rrqst;
            wacpt_q    <= 1'b1;
            state_q    <= W_AACK;
          end else if (rrqst) begin
            base_q    <= bus_addr[AW-1:2];
            wordcnt_q <= 2'd0;
            rrdy_q    <= 1'b1;
            state_q   <= R_ACK;
          end
        end
        R_ACK: begin
          lat_q   <= LAT_LOAD;
          state_q <= R_LAT;
        end
        R_LAT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q <= 4'd1) begin
            rd_data_q <= ram_rdata;
            rdrdy_q   <= 1'b1;
            state_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rdacpt) begin
            rdrdy_q <= 1'b0;
            state_q <= R_GAP;
          end
        end
        R_GAP: begin
          if (wordcnt_q == 2'd3) begin
            state_q <= IDLE;
          end else begin
            wordcnt_q <= next_word(wordcnt_q);
            lat_q     <= LAT_LOAD;
            state_q   <= R_LAT;
          end
        end
        W_AACK: begin
          if (!wrqst) begin
            wacpt_q <= 1'b0;
            state_q <= W_DWAIT;
          end
        end
        W_DWAIT: begin
          if (wrqst) begin
            wacpt_q <= 1'b1;
            state_q <= W_DACK;
          end
        end
        W_DACK: begin
          if (!wrqst) begin
            wacpt_q <= 1'b0;
            state_q <= W_DONE;
          end
        end
        W_DONE: begin
          rd_alloc_q <= 1'b0;
          if (rd_alloc_q) begin
            base_q    <= addr_q[AW-1:2];
            wordcnt_q <= 2'd0;
            lat_q     <= LAT_LOAD;
            state_q   <= R_LAT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/offchip_memory.md
OFFCHIP_MEMORY -- requirements
Module: offchip_memory

Interface
REQ-001 Parameter AW, default 10, word-address width; memory holds 2^AW 16-bit words.
REQ-002 Parameter LAT, default 2, range 1..15, idle cycles before each read word is presented.
REQ-003 clock  input  1  rising-edge clock; reset reset, synchronous, active-high; clock clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 rrqst  input  1  read request; offdata carries the address while high.
REQ-006 rrdy  output  1  read address accepted.
REQ-007 rdrdy  output  1  read word valid on offdata.
REQ-008 rdacpt  input  1  requester has taken the current read word.
REQ-009 wrqst  input  1  write request, address phase then data phase.
REQ-010 wacpt  output  1  write phase accepted.
REQ-011 offdata  inout  16  shared address/data bus; this block drives it only while rdrdy=1, else high-Z.

Function
REQ-012 States: IDLE, R_ACK, R_LAT, R_DATA, R_GAP, W_AACK, W_DWAIT, W_DACK, W_DONE.
REQ-013 IDLE, rrqst=1, wrqst=0: latch base = {offdata[AW-1:2],2'b00}, word counter=0, go to R_ACK.
REQ-014 R_ACK: rrdy=1 for exactly one cycle, then R_LAT with the latency counter loaded to LAT.
REQ-015 R_LAT: counter decrements each cycle; when it reaches 0, go to R_DATA.
REQ-016 R_DATA: rdrdy=1, offdata=mem[base+wordcnt], both held stable until rdacpt=1 is sampled; then R_GAP.
REQ-017 R_GAP: rdrdy=0, bus released for one cycle.
REQ-018 From R_GAP: if wordcnt=3, go to IDLE; else increment wordcnt and go to R_LAT.
REQ-019 Words are delivered in order 0,1,2,3 from the block base; wordcnt wraps within the block only.
REQ-020 IDLE, wrqst=1: latch full word address offdata[AW-1:0], latch rd_alloc=rrqst, assert wacpt, go to W_AACK.
REQ-021 W_AACK: hold wacpt=1 until wrqst=0 is sampled, then deassert wacpt and go to W_DWAIT.
REQ-022 W_DWAIT: on wrqst=1, write offdata to mem[addr] at that edge, assert wacpt, go to W_DACK.
REQ-023 W_DACK: hold wacpt until wrqst=0, then go to W_DONE.
REQ-024 W_DONE: if rd_alloc=1, set base = {addr[AW-1:2],2'b00}, wordcnt=0, and go to R_LAT with no rrdy pulse; else go to IDLE.
REQ-025 A write-allocate read returns the just-written word in its slot.
REQ-026 Simultaneous rrqst and wrqst in IDLE are treated as a write with allocate.
REQ-027 Requests are ignored outside IDLE, except the handshake inputs named for each state.
REQ-028 Address bits above AW-1 are ignored.
REQ-029 Reads are combinational from the array, registered onto offdata at R_DATA entry.

Reset
REQ-030 Reset sets state=IDLE, rrdy=0, rdrdy=0, wacpt=0, offdata=Z, and wordcnt, latency counter and rd_alloc to 0.
REQ-031 Reset mid-transaction aborts it within one cycle; array contents are preserved, and a write completes only if its W_DWAIT edge occurred.

Structure
REQ-032 Shared package holds the state enumeration, default AW and LAT, and the 16-bit word width constant.
REQ-033 The storage is a separate sub-module, offchip_ram, with one synchronous write port and one asynchronous read port.

Verification
REQ-034 Write 0xBEEF to 0x0045 (wrqst address/data phases, rrqst=0) -> wacpt pulses twice, mem[0x045]=0xBEEF, no rdrdy.
REQ-035 Preload 0x0040..0x0043 = 0x1111,0x2222,0x3333,0x4444, then rrqst with address 0x0042 -> one rrdy pulse; words returned in order 0x1111,0x2222,0x3333,0x4444; first rdrdy exactly LAT+1 cycles after rrdy.
REQ-036 requester delays rdacpt 5 cycles on word 1 -> rdrdy and offdata held stable for those 5 cycles, and no word is skipped or repeated.
REQ-037 wrqst with rrqst=1, address 0x0081, data 0xA5A5 -> write completes, then 4-word burst with no rrdy pulse and word 1 = 0xA5A5.
REQ-038 reset asserted during R_DATA of word 2 -> next cycle rdrdy=0 and offdata=Z; a new read returns the same array contents.
REQ-039 Every cycle -> bench checks offdata is driven if and only if rdrdy=1, and rrdy/wacpt never assert outside their states.
